// File: rtl/regfile_wb_arbiter.sv
// Write-side controller for the 8 x 16 register file: arbitrates ALU and load
// writebacks onto the single write port and tracks in-flight producers.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [2:0]  alu_tgt,
  input  logic [15:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [2:0]  mem_tgt,
  input  logic [15:0] mem_data,
  output logic        mem_ready,
  input  logic        iss_valid,
  input  logic [2:0]  iss_tgt,
  output logic        we_reg,
  output logic [2:0]  tgt,
  output logic [15:0] write_data,
  output logic [7:0]  busy_mask
);

  localparam int unsigned TGT_W  = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREG   = 8;
  localparam int unsigned CNT_W  = 4;

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              boost;
  logic              alu_acc;
  logic              mem_acc;
  logic              acc;
  logic [TGT_W-1:0]  win_tgt;
  logic [DATA_W-1:0] win_data;
  logic              we_d;
  logic [TGT_W-1:0]  tgt_d;
  logic [DATA_W-1:0] data_d;
  logic [NREG-1:0]   busy_d;

  // Arbitration: memory wins by default, ALU wins once it has been starved.
  always_comb begin
    boost     = (cnt_q == CNT_W'(STARVE_MAX));
    mem_ready = ~(alu_valid & boost);
    alu_ready = ~mem_valid | boost;
    mem_acc   = mem_valid & mem_ready;
    alu_acc   = alu_valid & alu_ready;
    acc       = mem_acc | alu_acc;
    win_tgt   = mem_acc ? mem_tgt  : alu_tgt;
    win_data  = mem_acc ? mem_data : alu_data;
  end

  // Next state for the write port, starvation counter and scoreboard.
  always_comb begin
    cnt_d  = cnt_q;
    we_d   = 1'b0;
    tgt_d  = tgt;
    data_d = write_data;
    busy_d = '0;

    if (acc) begin
      tgt_d  = win_tgt;
      data_d = win_data;
      we_d   = (win_tgt != '0);
    end

    if (alu_valid & mem_valid & ~boost) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (alu_acc | ~alu_valid) begin
      cnt_d = '0;
    end

    // A new issue supersedes a retiring producer to the same register.
    for (int unsigned i = 1; i < NREG; i++) begin
      busy_d[i] = (iss_valid & (iss_tgt == TGT_W'(i)))
                | (busy_mask[i] & ~(acc & (win_tgt == TGT_W'(i))));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      we_reg     <= 1'b0;
      tgt        <= '0;
      write_data <= '0;
      busy_mask  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      we_reg     <= we_d;
      tgt        <= tgt_d;
      write_data <= data_d;
      busy_mask  <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic compared every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int STARVE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [2:0]  alu_tgt = '0;
  logic [15:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [2:0]  mem_tgt = '0;
  logic [15:0] mem_data = '0;
  logic        mem_ready;
  logic        iss_valid = 1'b0;
  logic [2:0]  iss_tgt = '0;
  logic        we_reg;
  logic [2:0]  tgt;
  logic [15:0] write_data;
  logic [7:0]  busy_mask;

  int n_checks = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_tgt(alu_tgt), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_tgt(mem_tgt), .mem_data(mem_data), .mem_ready(mem_ready),
    .iss_valid(iss_valid), .iss_tgt(iss_tgt),
    .we_reg(we_reg), .tgt(tgt), .write_data(write_data), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: how many times in a row the ALU has lost, plus the
  // write port contents and the set of registers awaiting a producer.
  int          m_losses = 0;
  logic        m_we = 1'b0;
  logic [2:0]  m_tgt = '0;
  logic [15:0] m_data = '0;
  bit          m_busy [8];

  function automatic logic [7:0] busy_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_busy[i];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_losses = 0;
      m_we = 1'b0;
      m_tgt = '0;
      m_data = '0;
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
    end else begin
      bit starved, alu_wins, mem_wins, any;
      int wt;
      starved  = (m_losses == STARVE);
      alu_wins = alu_valid && (!mem_valid || starved);
      mem_wins = mem_valid && !(alu_valid && starved);
      any      = alu_wins || mem_wins;
      wt       = mem_wins ? int'(mem_tgt) : int'(alu_tgt);
      if (any) begin
        m_tgt  = 3'(wt);
        m_data = mem_wins ? mem_data : alu_data;
        m_we   = (wt != 0);
      end else begin
        m_we = 1'b0;
      end
      if (alu_valid && mem_valid && !starved) m_losses = m_losses + 1;
      else if (alu_wins || !alu_valid) m_losses = 0;
      for (int i = 1; i < 8; i++) begin
        if (iss_valid && int'(iss_tgt) == i) m_busy[i] = 1'b1;
        else if (any && wt == i) m_busy[i] = 1'b0;
      end
    end
  end

  // Compare process: every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("we_reg", 32'(we_reg), 32'(m_we));
      chk("tgt", 32'(tgt), 32'(m_tgt));
      chk("write_data", 32'(write_data), 32'(m_data));
      chk("busy_mask", 32'(busy_mask), 32'(busy_vec()));
      chk("alu_ready", 32'(alu_ready), 32'(!mem_valid || m_losses == STARVE));
      chk("mem_ready", 32'(mem_ready), 32'(!(alu_valid && m_losses == STARVE)));
    end
  end

  task automatic drive(input logic av, input logic [2:0] at, input logic [15:0] ad,
                       input logic mv, input logic [2:0] mt, input logic [15:0] md,
                       input logic iv, input logic [2:0] it);
    #2;
    alu_valid = av; alu_tgt = at; alu_data = ad;
    mem_valid = mv; mem_tgt = mt; mem_data = md;
    iss_valid = iv; iss_tgt = it;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_we", 32'(we_reg), 32'd0);
    chk("reset_busy", 32'(busy_mask), 32'h00);
    chk("reset_alu_ready", 32'(alu_ready), 32'd1);
    chk("reset_mem_ready", 32'(mem_ready), 32'd1);

    // Single ALU writeback
    drive(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    @(negedge clk);
    chk("alu_wb_we", 32'(we_reg), 32'd1);
    chk("alu_wb_tgt", 32'(tgt), 32'd3);
    chk("alu_wb_data", 32'(write_data), 32'hBEEF);
    idle();
    @(negedge clk);
    chk("alu_wb_we_drop", 32'(we_reg), 32'd0);

    // Both sources held: mem, mem, mem, alu, repeating
    drive(1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd5, 16'h5555, 1'b0, 3'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("starve_we", 32'(we_reg), 32'd1);
      chk("starve_tgt", 32'(tgt), (k % 4 == 3) ? 32'd2 : 32'd5);
    end
    idle();
    @(negedge clk);

    // Scoreboard set/clear, and set winning over a same-edge clear
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4);
    @(negedge clk);
    chk("sb_set", 32'(busy_mask), 32'h10);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h4444, 1'b0, 3'd0);
    @(negedge clk);
    chk("sb_clear", 32'(busy_mask), 32'h00);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4);
    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h4545, 1'b1, 3'd4);
    @(negedge clk);
    chk("sb_set_wins", 32'(busy_mask), 32'h10);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h4646, 1'b0, 3'd0);
    @(negedge clk);
    chk("sb_clear2", 32'(busy_mask), 32'h00);

    // Register 0 writeback and issue are both inert
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 16'h1234, 1'b0, 3'd0);
    #1 chk("r0_mem_ready", 32'(mem_ready), 32'd1);
    @(negedge clk);
    chk("r0_we", 32'(we_reg), 32'd0);
    chk("r0_data", 32'(write_data), 32'h1234);
    chk("r0_busy", 32'(busy_mask), 32'h00);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd7);
    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0);
    @(negedge clk);
    chk("r0_issue", 32'(busy_mask), 32'h80);
    drive(1'b1, 3'd7, 16'h7777, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    @(negedge clk);
    chk("r7_clear", 32'(busy_mask), 32'h00);

    // Asynchronous reset while a write is pending
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1);
    @(negedge clk);
    drive(1'b1, 3'd6, 16'hCAFE, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2);
    @(negedge clk);
    chk("pre_rst_we", 32'(we_reg), 32'd1);
    chk("pre_rst_busy", 32'(busy_mask), 32'h06);
    idle();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_we", 32'(we_reg), 32'd0);
    chk("rst_busy", 32'(busy_mask), 32'h00);
    chk("rst_tgt", 32'(tgt), 32'd0);
    chk("rst_data", 32'(write_data), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    drive(1'b1, 3'd2, 16'h2222, 1'b1, 3'd5, 16'h5050, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_tgt", 32'(tgt), (k == 3) ? 32'd2 : 32'd5);
    end

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
            1'($urandom_range(0, 2) == 0), 3'($urandom));
      @(negedge clk);
    end
    idle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
